// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between NREQ requesters.
// Registered sum/carry/id response with valid/ready backpressure.
module adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_y,
    output logic                      rsp_carry,
    output logic [$clog2(NREQ)-1:0]   rsp_id
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_eff;
    logic [IDW-1:0]  ptr_nxt;
    logic [IDW-1:0]  win_id;
    logic            win_found;
    logic [NREQ-1:0] win_oh;
    logic            accept_en;
    logic            grant;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]  sum;

    assign rsp_valid = (state == FULL);
    assign accept_en = !rsp_valid || rsp_ready;

    // Out-of-range pointer encodings restart the scan at requester 0.
    assign ptr_eff = (int'(rr_ptr) < NREQ) ? rr_ptr : '0;

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        win_oh    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_eff) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
        if (win_found) win_oh[win_id] = 1'b1;
    end

    assign req_ready = (!rst && accept_en) ? win_oh : '0;
    assign grant     = |req_ready;

    assign a_sel = req_a[int'(win_id)*WIDTH +: WIDTH];
    assign b_sel = req_b[int'(win_id)*WIDTH +: WIDTH];
    assign sum   = {1'b0, a_sel} + {1'b0, b_sel};

    assign ptr_nxt = (int'(win_id) == NREQ-1) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            rsp_y     <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            state              <= FULL;
            {rsp_carry, rsp_y} <= sum;
            rsp_id             <= win_id;
            rr_ptr             <= ptr_nxt;
        end else if (rsp_valid && rsp_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a queue-based response scoreboard.
// Stimulus pushes expected {id,carry,y}; a negedge monitor pops on handshakes.
module tb_adder_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_carry;
    logic [1:0]            rsp_id;

    int n_vec = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];

    adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_carry(rsp_carry), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a,
                          input logic [7:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input logic [1:0] id, input logic c,
                        input logic [7:0] y);
        exp_q.push_back({id, c, y});
    endtask

    task automatic nedge;
        @(negedge clk);
    endtask

    task automatic pedge;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            logic [10:0] e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d y=%0d c=%0d",
                         rsp_id, rsp_y, rsp_carry);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_carry, rsp_y} !== e) begin
                    n_err++;
                    $display("FAIL rsp: got id=%0d c=%0d y=%0d want id=%0d c=%0d y=%0d",
                             rsp_id, rsp_carry, rsp_y, e[10:9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        pedge;
        // Requests during reset must not be granted
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        nedge;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_y", 32'(rsp_y), 32'h0);
        chk("rst_carry", 32'(rsp_carry), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        pedge;

        // Single request
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 8'd5, 8'd3);
        nedge;
        chk("single_ready", 32'(req_ready), 32'h1);
        push(2'd0, 1'b0, 8'd8);
        pedge;
        req_valid = '0;
        nedge;
        chk("single_valid", 32'(rsp_valid), 32'h1);
        pedge;
        nedge;
        chk("single_drain", 32'(rsp_valid), 32'h0);
        pedge;

        // Carry / wrap arithmetic on requester 2
        req_valid = 4'b0100;
        set_op(2, 8'd50, 8'd5);
        nedge;
        chk("c1_ready", 32'(req_ready), 32'h4);
        push(2'd2, 1'b0, 8'd55);
        pedge;
        set_op(2, 8'd200, 8'd100);
        nedge;
        chk("c2_ready", 32'(req_ready), 32'h4);
        push(2'd2, 1'b1, 8'd44);
        pedge;
        set_op(2, 8'd255, 8'd1);
        nedge;
        chk("c3_ready", 32'(req_ready), 32'h4);
        push(2'd2, 1'b1, 8'd0);
        pedge;
        req_valid = '0;
        pedge;
        nedge;
        chk("c_drain", 32'(rsp_valid), 32'h0);

        // Round robin from reset
        rst = 1'b1;
        pedge;
        rst       = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++)
            set_op(i, 8'(10*(i+1)), 8'(i+1));
        for (int k = 0; k < 6; k++) begin
            int id;
            id = k % NREQ;
            nedge;
            chk("rr_ready", 32'(req_ready), 32'(1 << id));
            if (k > 0) chk("rr_valid", 32'(rsp_valid), 32'h1);
            push(2'(id), 1'b0, 8'(11*(id+1)));
            pedge;
        end

        // Backpressure on id1 response
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nedge;
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id", 32'(rsp_id), 32'h1);
            chk("bp_y", 32'(rsp_y), 32'd22);
            pedge;
        end
        rsp_ready = 1'b1;
        nedge;
        chk("bp_release", 32'(req_ready), 32'h4);
        pedge;

        // id2 result sits stalled, then is discarded by reset
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        nedge;
        chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
        chk("pre_rst_ready", 32'(req_ready), 32'h0);
        pedge;
        rst = 1'b1;
        nedge;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        pedge;
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        nedge;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_y", 32'(rsp_y), 32'h0);
        chk("mid_rst_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_ready2", 32'(req_ready), 32'h0);
        pedge;
        rst = 1'b0;
        nedge;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        push(2'd0, 1'b0, 8'd11);
        pedge;
        req_valid = 4'b1000;
        nedge;
        chk("post_rst_r3", 32'(req_ready), 32'h8);
        push(2'd3, 1'b0, 8'd44);
        pedge;
        req_valid = '0;
        pedge;

        // Dropped request while stalled
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        set_op(0, 8'd1, 8'd1);
        nedge;
        chk("drop_g0", 32'(req_ready), 32'h1);
        push(2'd0, 1'b0, 8'd2);
        pedge;
        req_valid = 4'b0010;
        nedge;
        chk("drop_stall", 32'(req_ready), 32'h0);
        pedge;
        req_valid = '0;
        pedge;
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        set_op(1, 8'd7, 8'd9);
        nedge;
        chk("drop_ptr", 32'(req_ready), 32'h2);
        push(2'd1, 1'b0, 8'd16);
        pedge;
        req_valid = '0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) pedge;
        pedge;
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        chk("end_valid", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
